// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack between a call/return unit (requester 0)
// and a data push/pop path (requester 1), sequencing strobes and screening full/empty.
module stack_arbiter #(
    parameter int WIDTH_DATA = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  op0,
    input  logic [WIDTH_DATA-1:0] wdata0,
    input  logic                  req1,
    input  logic                  op1,
    input  logic [WIDTH_DATA-1:0] wdata1,
    input  logic                  clr,
    output logic                  ack0,
    output logic                  ack1,
    output logic [WIDTH_DATA-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    output logic                  ovf_sticky,
    output logic                  unf_sticky,
    output logic                  st_push,
    output logic                  st_pop,
    output logic [WIDTH_DATA-1:0] st_data_in,
    input  logic [WIDTH_DATA-1:0] st_data_out,
    input  logic                  st_full,
    input  logic                  st_empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, POP_WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic                    prio;
    logic                    grant_id;
    logic                    grant_next;
    logic                    lat_op;
    logic [WIDTH_DATA-1:0]   lat_data;
    logic [WIDTH_DATA-1:0]   rdata_reg;
    logic                    err_reg;
    logic                    ovf_reg;
    logic                    unf_reg;
    logic                    issue_push, issue_pop, reject_push, reject_pop;

    // A lone requester always wins; on a tie the priority pointer decides.
    assign grant_next  = (req0 && (!req1 || !prio)) ? 1'b0 : 1'b1;

    assign issue_push  = (state == ISSUE) &&  lat_op && !st_full;
    assign reject_push = (state == ISSUE) &&  lat_op &&  st_full;
    assign issue_pop   = (state == ISSUE) && !lat_op && !st_empty;
    assign reject_pop  = (state == ISSUE) && !lat_op &&  st_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req0 || req1) state_next = ISSUE;
            ISSUE:    state_next = issue_pop ? POP_WAIT : RESP;
            POP_WAIT: state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Grant latch, response capture and sticky flags; clr beats a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            grant_id  <= 1'b0;
            lat_op    <= 1'b0;
            lat_data  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                grant_id <= grant_next;
                prio     <= ~grant_next;
                lat_op   <= grant_next ? op1 : op0;
                lat_data <= grant_next ? wdata1 : wdata0;
            end
            if (state == ISSUE) begin
                err_reg   <= reject_push || reject_pop;
                rdata_reg <= '0;
            end
            if (state == POP_WAIT) begin
                rdata_reg <= st_data_out;
            end
            if (state == RESP) begin
                err_reg   <= 1'b0;
                rdata_reg <= '0;
            end
            if (clr) begin
                ovf_reg <= 1'b0;
            end else if (reject_push) begin
                ovf_reg <= 1'b1;
            end
            if (clr) begin
                unf_reg <= 1'b0;
            end else if (reject_pop) begin
                unf_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        st_push    = issue_push;
        st_pop     = issue_pop;
        st_data_in = issue_push ? lat_data : '0;
        ack0       = (state == RESP) && !grant_id;
        ack1       = (state == RESP) &&  grant_id;
        err        = (state == RESP) &&  err_reg;
        rdata      = (state == RESP) ? rdata_reg : '0;
        busy       = (state != IDLE);
        ovf_sticky = ovf_reg;
        unf_sticky = unf_reg;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a 4-deep behavioural stack and an ack scoreboard.
module tb_stack_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, op0, req1, op1, clr;
    logic [W-1:0]  wdata0, wdata1;
    logic          ack0, ack1, err, busy, ovf_sticky, unf_sticky, st_push, st_pop;
    logic [W-1:0]  rdata, st_data_in, st_data_out;
    logic          st_full, st_empty;

    typedef struct {
        logic         id;
        logic         err;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         scb[$];
    int           checks = 0;
    int           errors = 0;
    int           push_cnt = 0;
    int           pop_cnt = 0;
    logic [W-1:0] last_push_data = '0;

    logic [W-1:0] mem [DEPTH];
    int           cnt = 0;
    logic [W-1:0] st_out = '0;

    localparam logic [W-1:0] DATA_A = 32'hA5A5_0001;
    localparam logic [W-1:0] DATA_B = 32'h5A5A_0002;

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH_DATA(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .clr(clr),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
        .st_push(st_push), .st_pop(st_pop), .st_data_in(st_data_in),
        .st_data_out(st_data_out), .st_full(st_full), .st_empty(st_empty)
    );

    // Stack model: read data registered on the pop edge, not reset by the arbiter.
    always @(posedge clk) begin
        if (st_push && cnt < DEPTH) begin
            mem[cnt] <= st_data_in;
            cnt      <= cnt + 1;
        end else if (st_pop && cnt > 0) begin
            st_out <= mem[cnt-1];
            cnt    <= cnt - 1;
        end
    end
    assign st_data_out = st_out;
    assign st_full     = (cnt == DEPTH);
    assign st_empty    = (cnt == 0);

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_flags"}, {24'b0, ack0, ack1, err, busy, ovf_sticky, unf_sticky, st_push, st_pop}, '0);
        checkOutput({tag, "_rdata"}, rdata, '0);
        checkOutput({tag, "_data_in"}, st_data_in, '0);
    endtask

    // Strobe accounting plus scoreboard consumption on every ack.
    always @(negedge clk) begin
        if (st_push) begin
            push_cnt++;
            last_push_data = st_data_in;
        end
        if (st_pop) pop_cnt++;
        if (st_push || st_pop) checkOutput("strobe_excl", {31'b0, st_push & st_pop}, '0);
        if (ack0 || ack1) begin
            checks++;
            assert (scb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_ack: observed ack0=%0b ack1=%0b expected none", ack0, ack1);
            end
            if (scb.size() > 0) begin
                exp_t e;
                e = scb.pop_front();
                checkOutput("ack_onehot", {31'b0, ack0 & ack1}, '0);
                checkOutput("ack_id", {31'b0, ack1}, {31'b0, e.id});
                checkOutput("ack_err", {31'b0, err}, {31'b0, e.err});
                checkOutput("ack_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic applyStimulus(input logic id, input logic op, input logic [W-1:0] data,
                                 input logic exp_err, input logic [W-1:0] exp_rdata);
        exp_t e;
        int   push_before, pop_before, lat;
        bit   seen;
        e.id = id; e.err = exp_err; e.rdata = exp_rdata;
        scb.push_back(e);
        push_before = push_cnt;
        pop_before  = pop_cnt;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; op1 = op; wdata1 = data; end
        else    begin req0 = 1'b1; op0 = op; wdata0 = data; end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = id ? ack1 : ack0;
        end
        // One negedge in the sampling IDLE cycle, then ISSUE, [POP_WAIT], RESP.
        checkOutput("latency", lat, (!op && !exp_err) ? 32'd4 : 32'd3);
        @(posedge clk); #1;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        checkOutput("push_strobes", push_cnt - push_before, (op && !exp_err) ? 32'd1 : 32'd0);
        checkOutput("pop_strobes", pop_cnt - pop_before, (!op && !exp_err) ? 32'd1 : 32'd0);
        if (op && !exp_err) checkOutput("push_data", last_push_data, data);
    endtask

    initial begin
        int   acks, waited, push_before, pop_before;
        exp_t e;
        reset = 1'b0;
        req0 = 1'b0; op0 = 1'b0; wdata0 = '0;
        req1 = 1'b0; op1 = 1'b0; wdata1 = '0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkQuiet("reset_init");
        reset = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 1'b0, '0, 1'b1, '0);
        checkOutput("unf_set", {31'b0, unf_sticky}, 32'd1);
        checkOutput("ovf_clear_after_pop", {31'b0, ovf_sticky}, '0);
        repeat (3) @(posedge clk);
        #1 checkOutput("unf_held", {31'b0, unf_sticky}, 32'd1);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        clr = 1'b0;
        checkOutput("unf_clr_wins", {31'b0, unf_sticky}, '0);

        @(posedge clk); #1 reset = 1'b0;
        #2 checkQuiet("reset_idle");
        @(posedge clk); #1 reset = 1'b1;

        // Both requesters held continuously: grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            e.id = (i % 2 == 1); e.err = 1'b0; e.rdata = '0;
            scb.push_back(e);
        end
        push_before = push_cnt;
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 1'b1; wdata0 = DATA_A;
        req1 = 1'b1; op1 = 1'b1; wdata1 = DATA_B;
        acks = 0;
        waited = 0;
        while (acks < 4 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (ack0 || ack1) acks++;
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        checkOutput("rr_acks", acks, 32'd4);
        checkOutput("rr_pushes", push_cnt - push_before, 32'd4);

        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b1, '0);
        checkOutput("ovf_set", {31'b0, ovf_sticky}, 32'd1);
        checkOutput("unf_still_clear", {31'b0, unf_sticky}, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, DATA_B);
        checkOutput("ovf_held", {31'b0, ovf_sticky}, 32'd1);

        // Reset during POP_WAIT: the strobe already hit the stack, but no ack follows.
        pop_before = pop_cnt;
        @(posedge clk); #1;
        req1 = 1'b1; op1 = 1'b0; wdata1 = '0;
        @(posedge clk);
        @(posedge clk);
        #2 checkOutput("popwait_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1 checkQuiet("reset_async");
        checkOutput("abort_pop_strobe", pop_cnt - pop_before, 32'd1);
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, DATA_B);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", scb.size(), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack instance between two requesters (requester 0: call/return unit; requester 1: data push/pop path) over a req/ack handshake.
- Round-robin arbitration; one stack operation at a time.
- Sequences the stack's strobe/registered-read timing and screens push-on-full / pop-on-empty.
- Sits between the requesters and the stack's push/pop/data_in/data_out/full/empty pins.

Parameters:
- WIDTH_DATA, 32, data word width; matches the stack instance.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0  in  1  requester 0 request; held high until ack0.
- op0  in  1  requester 0 operation: 1 = push, 0 = pop; stable while req0 high.
- wdata0  in  WIDTH_DATA  requester 0 push data; stable while req0 high.
- req1, op1, wdata1  in  1/1/WIDTH_DATA  same for requester 1.
- ack0  out  1  one-cycle completion pulse to requester 0.
- ack1  out  1  one-cycle completion pulse to requester 1.
- rdata  out  WIDTH_DATA  popped word; valid while ack0/ack1 high for a successful pop.
- err  out  1  high with ack when the operation was rejected (full/empty).
- busy  out  1  high in every state except IDLE.
- ovf_sticky  out  1  set on any rejected push; cleared by clr.
- unf_sticky  out  1  set on any rejected pop; cleared by clr.
- clr  in  1  synchronous clear of the sticky flags.
- st_push  out  1  push strobe to the stack.
- st_pop  out  1  pop strobe to the stack.
- st_data_in  out  WIDTH_DATA  push data to the stack.
- st_data_out  in  WIDTH_DATA  stack read data; registered one edge after st_pop.
- st_full  in  1  stack full flag.
- st_empty  in  1  stack empty flag.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE; priority pointer = requester 0.
  - All outputs 0, including latched op/data/id and rdata.
  - The stack's own reset is driven separately; this block does not reset the stack.
- FSM has four states: IDLE, ISSUE, POP_WAIT, RESP.
- IDLE:
  - If req0 and/or req1 is high, grant one requester and latch its id, op and wdata.
  - Both requesting: the requester named by the priority pointer wins. After each grant the pointer moves to the other requester.
  - Next state is ISSUE. With no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - Push, st_full = 0: st_push = 1 and st_data_in = latched data, then go to RESP (err = 0).
  - Push, st_full = 1: no strobe; set ovf_sticky; go to RESP (err = 1).
  - Pop, st_empty = 0: st_pop = 1, then go to POP_WAIT.
  - Pop, st_empty = 1: no strobe; set unf_sticky; go to RESP (err = 1).
  - st_push and st_pop are never high together, never high outside ISSUE, and never high more than one cycle per grant.
- POP_WAIT: st_data_out is valid during this cycle; capture it into rdata, then go to RESP.
- RESP:
  - Ack of the granted requester = 1 for one cycle; err as decided in ISSUE.
  - rdata holds the captured word on a successful pop, 0 otherwise.
  - Next state is IDLE.
- Latency, counted from the edge where IDLE samples req:
  - push ack is high in the 2nd cycle after it;
  - pop ack is high in the 3rd cycle after it.
  - No back-to-back grants: at least one IDLE cycle between ops. This guarantees st_full/st_empty have settled from the previous strobe.
- Requester rules:
  - Deasserting req before ack is illegal; a granted op still completes and acks.
  - After ack the requester must drop req or present a new op. A req still high in the IDLE cycle after ack is treated as a new request.
- Sticky flags: clr takes precedence over a simultaneous set.
- Reset mid-operation aborts the operation with no ack. Any strobe already issued stays applied to the stack.

Test Plan:
- Reset, then req0 push 0xDEADBEEF with the stack empty -> st_push high exactly one cycle with st_data_in = 0xDEADBEEF; ack0 = 1, err = 0 at the 2nd cycle after sampling.
- Then req1 pop -> st_pop pulses once; ack1 at the 3rd cycle with rdata = 0xDEADBEEF, err = 0.
- req0 and req1 rise in the same cycle right after reset -> requester 0 served first, then requester 1; with both held continuously, grants alternate 0,1,0,1.
- Pop with st_empty = 1 -> no st_pop; ack with err = 1; unf_sticky = 1 until clr; clr pulsed together with another failing pop -> flag reads 0.
- Push with st_full = 1 -> no st_push; err = 1; ovf_sticky = 1; a subsequent pop succeeds and returns the stack's top word.
- reset pulsed low during POP_WAIT -> all outputs 0 immediately (asynchronous), no ack; FSM idles and accepts a new request after release.
